scr1_div_imem_gen: RTL and testbench

SCR1_DIV_IMEM_GEN -- requirements
Module: scr1_div_imem_gen

---
 rtl/scr1_div_imem_gen.sv | 180 ++++++++++++++++++
 tb/tb_scr1_div_imem_gen.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/scr1_div_imem_gen.sv
// -----------------------------------------------------------------------------
// scr1_div_imem_gen
//
// Instruction-memory responder that feeds a fetching core an endless stream of
// RV32M divide instructions (DIV/DIVU/REM/REMU). Each aligned read returns the
// next word of the stream. The fetch address only selects OKAY vs ERROR. It
// never changes which word comes back.
//
// Handshake: imem_req_ack is high only in IDLE. A request is accepted on a
// rising edge with imem_req & imem_req_ack. The response appears for exactly
// one cycle, LATENCY cycles after the acceptance edge.
//
// Parameters
//   LATENCY    cycles from acceptance to response (1..4)
//   LFSR_SEED  reset value of the register-field LFSR
//
// Ports
//   clk           clock, all state on rising edge
//   rst           asynchronous active-high reset
//   imem_req      fetch request
//   imem_cmd      0 = read, 1 = write (writes are answered with ERROR)
//   imem_addr     fetch byte address (only [1:0] is examined)
//   imem_req_ack  request accepted (IDLE only)
//   imem_rdata    instruction word, 0 outside an OKAY response
//   imem_resp     00 IDLE, 01 OKAY, 10 ERROR
//   instr_cnt     number of OKAY responses, wrapping
//
// Build option
//   SCR1_DIV_GEN_RAND_EN  when defined, rs1/rs2 come from a 16-bit Fibonacci
//                         LFSR (taps 16,14,13,11) that advances once per OKAY
//                         response. rd and funct3 are the same in both builds.
// -----------------------------------------------------------------------------
module scr1_div_imem_gen #(
  parameter int unsigned LATENCY   = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_req,
  input  logic        imem_cmd,
  input  logic [31:0] imem_addr,
  output logic        imem_req_ack,
  output logic [31:0] imem_rdata,
  output logic [1:0]  imem_resp,
  output logic [15:0] instr_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam logic [1:0] RESP_IDLE  = 2'b00;
  localparam logic [1:0] RESP_OKAY  = 2'b01;
  localparam logic [1:0] RESP_ERROR = 2'b10;

  // WAIT holds for DLY_INIT+1 cycles, so RESP lands LATENCY cycles after acceptance.
  localparam logic [1:0] DLY_INIT = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

  // Reject configurations that cannot work. An all-zero seed would lock the LFSR.
  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("scr1_div_imem_gen: LATENCY must be 1..4");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("scr1_div_imem_gen: LFSR_SEED must be non-zero");
  end

  state_e      state;
  state_e      state_nxt;
  logic [1:0]  dly;
  logic [1:0]  dly_nxt;
  logic        cap_cmd;
  logic        cap_misal;
  logic [7:0]  n;
  logic [15:0] cnt;
  logic        accept;
  logic        resp_ok;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;

  // Address bits above [1:0] are deliberately ignored. The stream order alone
  // decides which instruction comes back.
  logic unused_addr;
  assign unused_addr = ^imem_addr[31:2];

  // Acknowledge is gated with rst so it stays low during reset, independent of clk.
  assign imem_req_ack = (state == ST_IDLE) && !rst;
  assign accept       = imem_req && imem_req_ack;
  assign resp_ok      = (state == ST_RESP) && !cap_cmd && !cap_misal;
  assign instr_cnt    = cnt;

`ifdef SCR1_DIV_GEN_RAND_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign rs1     = lfsr[4:0];
  assign rs2     = lfsr[9:5];
`else
  assign rs1     = n[4:0] + 5'd1;
  assign rs2     = n[4:0] + 5'd2;
`endif
  assign rd     = n[4:0];
  assign funct3 = {1'b1, n[1:0]};

  // Next-state logic
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case can
    // leave it unassigned and infer a latch.
    state_nxt = state;
    dly_nxt   = dly;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nxt = ST_RESP;
          end else begin
            state_nxt = ST_WAIT;
            dly_nxt   = DLY_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (dly == 2'd0) state_nxt = ST_RESP;
        else             dly_nxt   = dly - 2'd1;
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, captured request, stream index and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      dly       <= 2'd0;
      cap_cmd   <= 1'b0;
      cap_misal <= 1'b0;
      n         <= 8'd0;
      cnt       <= 16'd0;
`ifdef SCR1_DIV_GEN_RAND_EN
      lfsr      <= LFSR_SEED;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the values
      // from before this edge, whatever order the statements are written in.
      state <= state_nxt;
      dly   <= dly_nxt;
      if (accept) begin
        cap_cmd   <= imem_cmd;
        cap_misal <= |imem_addr[1:0];
      end
      // The stream advances only on OKAY. ERROR responses consume nothing.
      if (resp_ok) begin
        n   <= n + 8'd1;
        cnt <= cnt + 16'd1;
`ifdef SCR1_DIV_GEN_RAND_EN
        lfsr <= {lfsr[14:0], lfsr_fb};
`endif
      end
    end
  end

  // Response outputs are zero outside RESP. The ERROR data word is zero too.
  always_comb begin
    imem_resp  = RESP_IDLE;
    imem_rdata = 32'h0;
    if (state == ST_RESP) begin
      if (resp_ok) begin
        imem_resp  = RESP_OKAY;
        imem_rdata = {7'b0000001, rs2, rs1, funct3, rd, 7'b0110011};
      end else begin
        imem_resp  = RESP_ERROR;
      end
    end
  end

endmodule

// File: tb/tb_scr1_div_imem_gen.sv
// -----------------------------------------------------------------------------
// tb_scr1_div_imem_gen
//
// Directed bench for scr1_div_imem_gen. Two instances share one clock:
//   u_dut1  LATENCY=1  error handling, stream contents, 256-read wrap
//   u_dut3  LATENCY=3  back-to-back throughput, reset abort in WAIT
// Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_scr1_div_imem_gen;

  logic        clk = 1'b0;
  logic        rst1, rst3;
  logic        req1, cmd1, req3, cmd3;
  logic [31:0] addr1, addr3;
  logic        ack1, ack3;
  logic [31:0] rdata1, rdata3;
  logic [1:0]  resp1, resp3;
  logic [15:0] cnt1, cnt3;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference models: stream index, LFSR and OKAY count per instance
  logic [7:0]  m1_n, m3_n;
  logic [15:0] m1_lfsr, m3_lfsr;
  logic [15:0] m1_cnt, m3_cnt;

  always #5 clk = ~clk;

  scr1_div_imem_gen #(.LATENCY(1), .LFSR_SEED(16'hACE1)) u_dut1 (
    .clk(clk), .rst(rst1), .imem_req(req1), .imem_cmd(cmd1), .imem_addr(addr1),
    .imem_req_ack(ack1), .imem_rdata(rdata1), .imem_resp(resp1), .instr_cnt(cnt1)
  );

  scr1_div_imem_gen #(.LATENCY(3), .LFSR_SEED(16'hACE1)) u_dut3 (
    .clk(clk), .rst(rst3), .imem_req(req3), .imem_cmd(cmd3), .imem_addr(addr3),
    .imem_req_ack(ack3), .imem_rdata(rdata3), .imem_resp(resp3), .instr_cnt(cnt3)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [7:0] idx, input logic [15:0] lf);
    logic [4:0] rs1, rs2;
`ifdef SCR1_DIV_GEN_RAND_EN
    rs1 = lf[4:0];
    rs2 = lf[9:5];
`else
    rs1 = idx[4:0] + 5'd1;
    rs2 = idx[4:0] + 5'd2;
    if (lf == 16'h0) rs1 = rs1;  // LFSR state has no effect in this build
`endif
    return {7'b0000001, rs2, rs1, 1'b1, idx[1:0], idx[4:0], 7'b0110011};
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // One LATENCY=1 transaction; entered and left just after a falling edge.
  task automatic rd1(input logic cmd, input logic [31:0] addr, input string tag,
                     output logic [31:0] word);
    logic        ok;
    logic [31:0] exp;
    check({tag, ".ack_idle"}, 32'(ack1), 32'd1);
    req1 = 1'b1; cmd1 = cmd; addr1 = addr;
    @(negedge clk);
    req1 = 1'b0;
    ok  = !cmd && (addr[1:0] == 2'b00);
    exp = ok ? exp_word(m1_n, m1_lfsr) : 32'h0;
    check({tag, ".resp"},  32'(resp1), ok ? 32'd1 : 32'd2);
    check({tag, ".rdata"}, rdata1, exp);
    check({tag, ".ack_busy"}, 32'(ack1), 32'd0);
    word = rdata1;
    if (ok) begin
      m1_n++;
      m1_cnt++;
      m1_lfsr = lfsr_step(m1_lfsr);
    end
    @(negedge clk);
    check({tag, ".cnt"}, 32'(cnt1), 32'(m1_cnt));
  endtask

  initial begin
    logic [31:0] w, w0;
    rst1 = 1'b1; rst3 = 1'b1;
    req1 = 1'b0; cmd1 = 1'b0; addr1 = 32'h0;
    req3 = 1'b0; cmd3 = 1'b0; addr3 = 32'h0;
    m1_n = 8'd0; m1_lfsr = 16'hACE1; m1_cnt = 16'd0;
    m3_n = 8'd0; m3_lfsr = 16'hACE1; m3_cnt = 16'd0;

    // Outputs held at zero during reset
    @(negedge clk);
    @(negedge clk);
    check("rst.ack",   32'(ack1),  32'd0);
    check("rst.resp",  32'(resp1), 32'd0);
    check("rst.rdata", rdata1,     32'h0);
    check("rst.cnt",   32'(cnt1),  32'd0);
    rst1 = 1'b0; rst3 = 1'b0;
    #1;
    check("rst.ack_rise", 32'(ack1), 32'd1);

    // Write and misaligned read give ERROR, stream does not advance
    rd1(1'b1, 32'h0000_0200, "err_write", w);
    rd1(1'b0, 32'h0000_0202, "err_misal", w);
    check("err.cnt_kept", 32'(cnt1), 32'd0);

    // First aligned read returns the index-0 word
    rd1(1'b0, 32'h0000_0200, "read0", w);
    w0 = w;
`ifndef SCR1_DIV_GEN_RAND_EN
    check("read0.word", w, 32'h0220C033);
`else
    check("read0.rs1", 32'(w[19:15]), 32'd1);
    check("read0.rs2", 32'(w[24:20]), 32'd7);
`endif
    check("read0.cnt", 32'(cnt1), 32'd1);
    rd1(1'b0, 32'h0000_0204, "read1", w);
`ifndef SCR1_DIV_GEN_RAND_EN
    check("read1.word", w, 32'h023150B3);
`endif
    check("read1.f3", 32'(w[14:12]), 32'b101);
    rd1(1'b0, 32'h0000_1000, "read2", w);
    check("read2.f3", 32'(w[14:12]), 32'b110);
    rd1(1'b0, 32'hFFFF_FFFC, "read3", w);
    check("read3.f3", 32'(w[14:12]), 32'b111);

    // Complete 256 reads, then index wraps back to 0
    for (int i = 4; i < 256; i++) rd1(1'b0, 32'(i * 4), "stream", w);
    check("wrap.cnt", 32'(cnt1), 32'd256);
    rd1(1'b0, 32'h0000_0000, "wrap", w);
    check("wrap.rd_f3", 32'(w[14:7]), {24'h0, 3'b100, 5'd0});
`ifndef SCR1_DIV_GEN_RAND_EN
    check("wrap.word", w, w0);
`endif

    // LATENCY=3, request held high: accept every 4th cycle, resp 3 cycles later
    req3 = 1'b1; cmd3 = 1'b0; addr3 = 32'h0000_0100;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("thru.ack%0d", k),  32'(ack3),  (k % 4 == 0) ? 32'd1 : 32'd0);
      check($sformatf("thru.resp%0d", k), 32'(resp3), (k % 4 == 3) ? 32'd1 : 32'd0);
      if (k % 4 == 3) begin
        check($sformatf("thru.rdata%0d", k), rdata3, exp_word(m3_n, m3_lfsr));
        m3_n++; m3_cnt++; m3_lfsr = lfsr_step(m3_lfsr);
      end else begin
        check($sformatf("thru.rdata%0d", k), rdata3, 32'h0);
      end
    end
    req3 = 1'b0;
    @(negedge clk);
    check("thru.cnt", 32'(cnt3), 32'(m3_cnt));

    // Reset pulsed in WAIT aborts the transaction
    req3 = 1'b1;
    @(negedge clk);
    req3 = 1'b0;
    rst3 = 1'b1;
    #1;
    check("abort.ack",   32'(ack3),  32'd0);
    check("abort.resp",  32'(resp3), 32'd0);
    check("abort.rdata", rdata3,     32'h0);
    check("abort.cnt",   32'(cnt3),  32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort.resp_in_rst", 32'(resp3), 32'd0);
    end
    rst3 = 1'b0;
    m3_n = 8'd0; m3_lfsr = 16'hACE1; m3_cnt = 16'd0;
    #1;
    check("abort.ack_rise", 32'(ack3), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort.no_resp", 32'(resp3), 32'd0);
    end
    req3 = 1'b1;
    @(negedge clk);
    req3 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("after.resp", 32'(resp3), 32'd1);
    check("after.rdata", rdata3, exp_word(m3_n, m3_lfsr));
`ifndef SCR1_DIV_GEN_RAND_EN
    check("after.word", rdata3, 32'h0220C033);
`endif
    @(negedge clk);
    check("after.cnt", 32'(cnt3), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
